dbus_arbiter: RTL

- Two-master, single-slave arbiter for the data-memory word bus, i.e. the bus after the data aligner, ahead of dmem and the LED MMIO decode.
- Master 0 is the core MEM stage. Master 1 is a secondary requester, such as a program/data loader or DMA.
- Fixed priority to the core, with a starvation guard that forces a grant to master 1 after a bounded wait.
- Routes 1-cycle-latency read data back to the master that issued the read.

---
 rtl/dbus_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-master data bus arbiter with starvation guard
// Core (M0) has fixed priority; M1 is force-granted after STARVE_LIMIT denied cycles.
module dbus_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int CW           = 8
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        M0_REQ,
   input  logic        M0_WE,
   input  logic [29:0] M0_ADDR,
   input  logic [31:0] M0_WDATA,
   input  logic [3:0]  M0_WSTB,
   output logic        M0_GNT,
   output logic        M0_RVALID,
   output logic [31:0] M0_RDATA,
   input  logic        M1_REQ,
   input  logic        M1_WE,
   input  logic [29:0] M1_ADDR,
   input  logic [31:0] M1_WDATA,
   input  logic [3:0]  M1_WSTB,
   output logic        M1_GNT,
   output logic        M1_RVALID,
   output logic [31:0] M1_RDATA,
   output logic        S_CE,
   output logic        S_WE,
   output logic [29:0] S_ADDR,
   output logic [31:0] S_WDATA,
   output logic [3:0]  S_WSTB,
   input  logic [31:0] S_RDATA
);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic          rd_pend_q, rd_pend_d;
   logic          rd_tag_q, rd_tag_d;
   logic          force_m1;
   logic          m0_gnt, m1_gnt;

   // Grants are suppressed combinationally while reset is low so no slave write can slip through.
   always_comb begin
      force_m1 = (starve_cnt_q == LIMIT);
      m0_gnt   = 1'b0;
      m1_gnt   = 1'b0;
      if (RSTN) begin
         m1_gnt = M1_REQ & (~M0_REQ | force_m1);
         m0_gnt = M0_REQ & ~m1_gnt;
      end
   end

   assign M0_GNT = m0_gnt;
   assign M1_GNT = m1_gnt;
   assign S_CE   = m0_gnt | m1_gnt;

   always_comb begin
      S_WE    = 1'b0;
      S_ADDR  = '0;
      S_WDATA = '0;
      S_WSTB  = '0;
      if (m0_gnt) begin
         S_WE    = M0_WE;
         S_ADDR  = M0_ADDR;
         S_WDATA = M0_WDATA;
         S_WSTB  = M0_WE ? M0_WSTB : 4'b0000;
      end else if (m1_gnt) begin
         S_WE    = M1_WE;
         S_ADDR  = M1_ADDR;
         S_WDATA = M1_WDATA;
         S_WSTB  = M1_WE ? M1_WSTB : 4'b0000;
      end
   end

   always_comb begin
      starve_cnt_d = '0;
      if (M1_REQ && !m1_gnt) begin
         starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 1'b1;
      end
      rd_pend_d = S_CE & ~S_WE;
      rd_tag_d  = rd_pend_d ? m1_gnt : rd_tag_q;
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         starve_cnt_q <= '0;
         rd_pend_q    <= 1'b0;
         rd_tag_q     <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rd_pend_q    <= rd_pend_d;
         rd_tag_q     <= rd_tag_d;
      end
   end

   // Read data passes straight through to whichever master owns the pending read.
   assign M0_RVALID = rd_pend_q & ~rd_tag_q;
   assign M1_RVALID = rd_pend_q & rd_tag_q;
   assign M0_RDATA  = M0_RVALID ? S_RDATA : 32'h0;
   assign M1_RDATA  = M1_RVALID ? S_RDATA : 32'h0;

endmodule
